// File: rtl/udp_tx_transport_layer.sv
// UDP transmit transport layer: buffers one payload frame, then emits the 8-byte header and the payload.
// Define UDP_TX_CSUM_EN to generate the checksum; otherwise the checksum field is sent as 0x0000.
module udp_tx_transport_layer #(
  parameter int BUF_AW = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic [15:0] upper_len,
  input  logic [15:0] pseudo_crc_sum,
  input  logic        upper_op_st,
  input  logic        upper_op,
  input  logic        upper_op_end,
  input  logic [31:0] upper_data,
  output logic        upper_rdy,
  input  logic        snd_rdy,
  output logic        snd_op_st,
  output logic        snd_op,
  output logic        snd_op_end,
  output logic [31:0] snd_data,
  output logic        buf_ovf
);
  localparam int DEPTH = 1 << BUF_AW;
  localparam logic [BUF_AW:0] FULL = (BUF_AW+1)'(DEPTH);
  localparam logic [BUF_AW:0] ONE  = (BUF_AW+1)'(1);

  typedef enum logic [2:0] {IDLE, LOAD, CSUM, HDR0, HDR1, DATA} state_t;
  state_t state;

  logic [31:0]     mem [DEPTH];
  logic [BUF_AW:0] wr_ptr, rd_ptr;
  logic [15:0]     src_q, dst_q, len_q, ck_q;

  logic        start, take, store, ovf, done;
  logic [15:0] cur_len, udp_len, ck;
  logic [16:0] need;
  logic [31:0] byte_mask, wdata;

  // Ports/length are taken straight from the inputs on the start word, from the latches afterwards.
  assign start   = (state == IDLE) && upper_op && upper_op_st;
  assign take    = start || ((state == LOAD) && upper_op);
  assign cur_len = (state == IDLE) ? upper_len : len_q;
  assign need    = ({1'b0, cur_len} + 17'd3) >> 2;
  assign store   = take && (32'(wr_ptr) < 32'(need));
  assign ovf     = store && (wr_ptr == FULL);
  assign udp_len = len_q + 16'd8;
  assign done    = snd_rdy && (((state == HDR1) && (wr_ptr == '0)) ||
                               ((state == DATA) && snd_op_end));

  always_comb begin
    byte_mask = '1;
    if (32'(wr_ptr) + 32'd1 == 32'(need)) begin
      case (cur_len[1:0])
        2'd1:    byte_mask = 32'hFF00_0000;
        2'd2:    byte_mask = 32'hFFFF_0000;
        2'd3:    byte_mask = 32'hFFFF_FF00;
        default: byte_mask = '1;
      endcase
    end
  end
  assign wdata = upper_data & byte_mask;

  always_ff @(posedge clk)
    if (store && !ovf) mem[wr_ptr[BUF_AW-1:0]] <= wdata;

`ifdef UDP_TX_CSUM_EN
  logic [31:0] sum, sum_base, sum_word, tot;
  logic [32:0] s33, t33;
  logic [16:0] f1;
  logic [15:0] f2;

  // Header fields known at frame start seed the accumulator; udp_len is added in CSUM.
  assign sum_base = (state == IDLE) ? 32'(pseudo_crc_sum) + 32'(src_port) + 32'(dst_port) : sum;
  assign s33      = {1'b0, sum_base} + 33'(wdata[31:16]) + 33'(wdata[15:0]);
  assign sum_word = s33[31:0] + 32'(s33[32]);
  assign t33      = {1'b0, sum} + 33'({udp_len, 1'b0});
  assign tot      = t33[31:0] + 32'(t33[32]);
  assign f1       = {1'b0, tot[31:16]} + {1'b0, tot[15:0]};
  assign f2       = f1[15:0] + 16'(f1[16]);
  assign ck       = (f2 == 16'hFFFF) ? 16'hFFFF : ~f2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 sum <= '0;
    else if (start)                          sum <= store ? sum_word : sum_base;
    else if ((state == LOAD) && store && !ovf) sum <= sum_word;
  end
`else
  logic unused_csum;
  assign unused_csum = ^pseudo_crc_sum;
  assign ck = 16'h0000;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      ck_q       <= '0;
      upper_rdy  <= 1'b1;
      snd_op_st  <= 1'b0;
      snd_op     <= 1'b0;
      snd_op_end <= 1'b0;
      snd_data   <= '0;
      buf_ovf    <= 1'b0;
    end else begin
      buf_ovf <= 1'b0;
      case (state)
        IDLE: if (start) begin
          src_q  <= src_port;
          dst_q  <= dst_port;
          len_q  <= upper_len;
          wr_ptr <= store ? ONE : '0;
          if (upper_op_end) begin
            state     <= CSUM;
            upper_rdy <= 1'b0;
          end else begin
            state <= LOAD;
          end
        end
        LOAD: if (upper_op) begin
          if (ovf) begin
            buf_ovf <= 1'b1;
            wr_ptr  <= '0;
            state   <= IDLE;
          end else begin
            if (store) wr_ptr <= wr_ptr + ONE;
            if (upper_op_end) begin
              state     <= CSUM;
              upper_rdy <= 1'b0;
            end
          end
        end
        CSUM: begin
          ck_q       <= ck;
          snd_op     <= 1'b1;
          snd_op_st  <= 1'b1;
          snd_op_end <= 1'b0;
          snd_data   <= {src_q, dst_q};
          state      <= HDR0;
        end
        HDR0: if (snd_rdy) begin
          snd_op_st  <= 1'b0;
          snd_data   <= {udp_len, ck_q};
          snd_op_end <= (wr_ptr == '0);
          state      <= HDR1;
        end
        HDR1: if (snd_rdy && (wr_ptr != '0)) begin
          snd_data   <= mem[0];
          rd_ptr     <= ONE;
          snd_op_end <= (wr_ptr == ONE);
          state      <= DATA;
        end
        DATA: if (snd_rdy && !snd_op_end) begin
          snd_data   <= mem[rd_ptr[BUF_AW-1:0]];
          rd_ptr     <= rd_ptr + ONE;
          snd_op_end <= (rd_ptr + ONE == wr_ptr);
        end
        default: state <= IDLE;
      endcase
      // Last word accepted: release the buffer for the next frame.
      if (done) begin
        state      <= IDLE;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        snd_op     <= 1'b0;
        snd_op_st  <= 1'b0;
        snd_op_end <= 1'b0;
        snd_data   <= '0;
        upper_rdy  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_udp_tx_transport_layer.sv
// Directed bench for udp_tx_transport_layer (BUF_AW=2); expected checksums follow UDP_TX_CSUM_EN.
module tb_udp_tx_transport_layer;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] src_port, dst_port, upper_len, pseudo_crc_sum;
  logic        upper_op_st, upper_op, upper_op_end;
  logic [31:0] upper_data;
  logic        upper_rdy, snd_rdy, snd_op_st, snd_op, snd_op_end, buf_ovf;
  logic [31:0] snd_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] in_q[$];
  logic [31:0] exp_q[$];

`ifdef UDP_TX_CSUM_EN
  localparam logic [15:0] CK1 = 16'h9335, CK2 = 16'h319F, CK4 = 16'h96FF, CK5 = 16'hFFFF, CK6 = 16'hFFEC;
`else
  localparam logic [15:0] CK1 = 16'h0, CK2 = 16'h0, CK4 = 16'h0, CK5 = 16'h0, CK6 = 16'h0;
`endif

  always #5 clk = ~clk;

  udp_tx_transport_layer #(.BUF_AW(2)) dut (
    .clk(clk), .rst(rst),
    .src_port(src_port), .dst_port(dst_port), .upper_len(upper_len), .pseudo_crc_sum(pseudo_crc_sum),
    .upper_op_st(upper_op_st), .upper_op(upper_op), .upper_op_end(upper_op_end), .upper_data(upper_data),
    .upper_rdy(upper_rdy), .snd_rdy(snd_rdy),
    .snd_op_st(snd_op_st), .snd_op(snd_op), .snd_op_end(snd_op_end), .snd_data(snd_data),
    .buf_ovf(buf_ovf)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic hdr(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l, input logic [15:0] p);
    src_port = s; dst_port = d; upper_len = l; pseudo_crc_sum = p;
  endtask

  // Drives in_q as one frame; returns at the negedge where the FSM sits in CSUM.
  task automatic send_frame();
    for (int i = 0; i < in_q.size(); i++) begin
      upper_op     = 1'b1;
      upper_op_st  = (i == 0);
      upper_op_end = (i == in_q.size() - 1);
      upper_data   = in_q[i];
      tick();
    end
    upper_op = 1'b0; upper_op_st = 1'b0; upper_op_end = 1'b0; upper_data = '0;
  endtask

  task automatic chk_word(input string tag, input int k);
    chk($sformatf("%s:data%0d", tag, k), snd_data, exp_q[k]);
    chk($sformatf("%s:flags%0d", tag, k), 32'({snd_op, snd_op_st, snd_op_end}),
        32'({1'b1, k == 0, k == exp_q.size() - 1}));
  endtask

  // Checks the CSUM gap, then every output word of exp_q; optional stall on word stall_k.
  task automatic expect_frame(input string tag, input int stall_k, input int stall_n);
    chk({tag, ":gap_op"}, 32'(snd_op), 32'd0);
    chk({tag, ":gap_rdy"}, 32'(upper_rdy), 32'd0);
    tick();
    for (int k = 0; k < exp_q.size(); k++) begin
      chk_word(tag, k);
      if (k == stall_k) begin
        snd_rdy = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk_word({tag, ":stall"}, k);
        end
        snd_rdy = 1'b1;
      end
      tick();
    end
    chk({tag, ":end_op"}, 32'(snd_op), 32'd0);
    chk({tag, ":end_rdy"}, 32'(upper_rdy), 32'd1);
  endtask

  initial begin
    rst = 1'b1; snd_rdy = 1'b1;
    upper_op = 1'b0; upper_op_st = 1'b0; upper_op_end = 1'b0; upper_data = '0;
    hdr(16'h0, 16'h0, 16'h0, 16'h0);
    tick(); tick();
    chk("reset:rdy", 32'(upper_rdy), 32'd1);
    chk("reset:outs", 32'({snd_op, snd_op_st, snd_op_end, buf_ovf}), 32'd0);
    chk("reset:data", snd_data, 32'd0);
    rst = 1'b0;
    tick();

    // Word without op_st in IDLE is ignored
    upper_op = 1'b1; upper_op_end = 1'b1; upper_data = 32'h11111111;
    tick();
    upper_op = 1'b0; upper_op_end = 1'b0;
    tick(); tick();
    chk("nost:op", 32'(snd_op), 32'd0);
    chk("nost:rdy", 32'(upper_rdy), 32'd1);

    // 1: single word frame
    hdr(16'h1234, 16'h5678, 16'd4, 16'h0000);
    in_q = '{32'h01020304};
    exp_q = '{32'h12345678, {16'h000C, CK1}, 32'h01020304};
    send_frame();
    expect_frame("t1", -1, 0);

    // 2: len=5, tail bytes of the last word are masked
    hdr(16'h1234, 16'h5678, 16'd5, 16'h0000);
    in_q = '{32'hAABBCCDD, 32'hEEFF1122};
    exp_q = '{32'h12345678, {16'h000D, CK2}, 32'hAABBCCDD, 32'hEE000000};
    send_frame();
    expect_frame("t2", -1, 0);

    // 3: stall 3 cycles on HDR1
    hdr(16'h1234, 16'h5678, 16'd4, 16'h0000);
    in_q = '{32'h01020304};
    exp_q = '{32'h12345678, {16'h000C, CK1}, 32'h01020304};
    send_frame();
    expect_frame("t3", 1, 3);

    // Exactly full buffer (4 words) is not an overflow
    hdr(16'h1234, 16'h5678, 16'd16, 16'h0000);
    in_q = '{32'h00010002, 32'h00030004, 32'h00050006, 32'h00070008};
    exp_q = '{32'h12345678, {16'h0018, CK4}, 32'h00010002, 32'h00030004, 32'h00050006, 32'h00070008};
    send_frame();
    chk("full:noovf", 32'(buf_ovf), 32'd0);
    expect_frame("full", -1, 0);

    // 4: fifth stored word overflows and drops the frame
    hdr(16'h1234, 16'h5678, 16'd20, 16'h0000);
    in_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    send_frame();
    chk("ovf:pulse", 32'(buf_ovf), 32'd1);
    chk("ovf:rdy", 32'(upper_rdy), 32'd1);
    tick();
    chk("ovf:pulse_end", 32'(buf_ovf), 32'd0);
    tick(); tick();
    chk("ovf:no_op", 32'(snd_op), 32'd0);
    hdr(16'h1234, 16'h5678, 16'd4, 16'h0000);
    in_q = '{32'h01020304};
    exp_q = '{32'h12345678, {16'h000C, CK1}, 32'h01020304};
    send_frame();
    expect_frame("ovf:next", -1, 0);

    // 5: sum folds to 0xFFFF, checksum sent as 0xFFFF (0x0000 without checksum logic)
    hdr(16'h1234, 16'h5678, 16'd4, 16'h9335);
    in_q = '{32'h01020304};
    exp_q = '{32'h12345678, {16'h000C, CK5}, 32'h01020304};
    send_frame();
    expect_frame("t5", -1, 0);

    // 6: reset during DATA, then an empty frame
    hdr(16'h1234, 16'h5678, 16'd5, 16'h0000);
    in_q = '{32'hAABBCCDD, 32'hEEFF1122};
    send_frame();
    tick(); tick(); tick();
    chk("t6:in_data", snd_data, 32'hAABBCCDD);
    rst = 1'b1;
    #1;
    chk("t6:rst_op", 32'(snd_op), 32'd0);
    chk("t6:rst_rdy", 32'(upper_rdy), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    hdr(16'h0001, 16'h0002, 16'd0, 16'h0000);
    in_q = '{32'hDEADBEEF};
    exp_q = '{32'h00010002, {16'h0008, CK6}};
    send_frame();
    expect_frame("t6", -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
